// File: rtl/sarray_rd_loader.sv
`default_nettype none
// ============================================================================
// Module   : sarray_rd_loader
// Purpose  : Strided scratchpad read engine feeding the systolic-array rows
//            through a credit-protected response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sarray_rd_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 2048,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_stride_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  sarray_ar_valid_o,
    input  logic                  sarray_ar_ready_i,
    output logic [ADDR_WIDTH-1:0] sarray_ar_addr_o,
    input  logic                  sarray_r_valid_i,
    output logic                  sarray_r_ready_o,
    input  logic [DATA_WIDTH-1:0] sarray_r_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_popped;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                  r_err;

    logic                  w_credit_ok;
    logic                  w_ar_hs;
    logic                  w_push;
    logic                  w_pop;
    logic [LEN_WIDTH-1:0]  w_popped_nxt;

    // A request may only go out when its response already has a FIFO slot.
    assign w_credit_ok  = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CNT_W+1)'(FIFO_DEPTH);
    assign w_ar_hs      = sarray_ar_valid_o & sarray_ar_ready_i;
    assign w_push       = sarray_r_valid_i & (r_outstanding != '0);
    assign w_pop        = out_valid_o & out_ready_i;
    assign w_popped_nxt = r_popped + LEN_WIDTH'(w_pop);

    assign cmd_ready_o       = (r_state == S_IDLE);
    assign sarray_ar_valid_o = (r_state == S_ISSUE) & (r_issued < r_len) & w_credit_ok;
    assign sarray_ar_addr_o  = r_addr;
    assign sarray_r_ready_o  = 1'b1;
    assign out_valid_o       = (r_count != '0);
    assign out_data_o        = r_mem[r_rptr];
    assign out_last_o        = out_valid_o & (r_popped == r_len - LEN_WIDTH'(1));
    assign busy_o            = (r_state != S_IDLE);
    assign done_o            = (r_state == S_DONE);
    assign err_o             = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_stride      <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_popped      <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_err         <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_popped      <= w_popped_nxt;
            r_outstanding <= r_outstanding + CNT_W'(w_ar_hs) - CNT_W'(w_push);
            r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_push) begin
                r_mem[r_wptr] <= sarray_r_data_i;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (sarray_r_valid_i && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_addr   <= cmd_addr_i;
                        r_stride <= cmd_stride_i;
                        r_len    <= cmd_len_i;
                        r_issued <= '0;
                        r_popped <= '0;
                        r_state  <= (cmd_len_i != '0) ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (w_ar_hs) begin
                        r_addr   <= r_addr + r_stride;
                        r_issued <= r_issued + LEN_WIDTH'(1);
                        if (r_issued + LEN_WIDTH'(1) == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_popped_nxt == r_len) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sarray_rd_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sarray_rd_loader
// Purpose  : Self-checking bench with a scratchpad model and a line-list
//            reference for sarray_rd_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sarray_rd_loader;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_stride;
    logic [LW-1:0] cmd_len;
    logic          ar_valid;
    logic          ar_ready;
    logic [AW-1:0] ar_addr;
    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    sarray_rd_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_addr_i        (cmd_addr),
        .cmd_stride_i      (cmd_stride),
        .cmd_len_i         (cmd_len),
        .sarray_ar_valid_o (ar_valid),
        .sarray_ar_ready_i (ar_ready),
        .sarray_ar_addr_o  (ar_addr),
        .sarray_r_valid_i  (r_valid),
        .sarray_r_ready_o  (r_ready),
        .sarray_r_data_i   (r_data),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_data_o        (out_data),
        .out_last_o        (out_last),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] stride;
        logic [15:0] len;
        int          ar_pct;
        int          out_pct;
        int          stall;
        bit          fixed_lat;
        bit          b2b;
        int          exp_stall_hs;
        logic [31:0] exp_last_addr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    vec_t        cur;
    vec_t        tbl [6];
    rsp_t        pend [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          hs, pops, delivered, dones;
    int          cmd_cyc, last_pop_cyc, first_hs_cyc, last_hs_cyc, last_due;
    int          stall_left;
    bit          want_cmd, cmd_fire, accepted, prev_wait, err_exp;
    logic [31:0] prev_addr, last_ar_addr;

    function automatic logic [31:0] line_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_ar_valid"},  64'(ar_valid),  64'd0);
        chk({tag, "_ar_addr"},   64'(ar_addr),   64'd0);
        chk({tag, "_r_ready"},   64'(r_ready),   64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
        chk({tag, "_out_data"},  64'(out_data),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_err"},       64'(err),       64'd0);
    endtask

    task automatic model_clear();
        pend.delete();
        hs = 0; pops = 0; delivered = 0; dones = 0;
        want_cmd = 0; cmd_fire = 0; accepted = 0; prev_wait = 0;
        stall_left = 0; last_due = 0;
    endtask

    // Loads the expected line list for a command; expectations come from
    // addr + i*stride computed directly, not by stepping an address register.
    task automatic model_setup(input vec_t v);
        cur = v;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < int'(v.len); i++) begin
            exp_addr.push_back(v.addr + v.stride * 32'(i));
            exp_data.push_back(line_data(v.addr + v.stride * 32'(i)));
        end
        hs = 0; pops = 0; delivered = 0; dones = 0;
        want_cmd = 1;
    endtask

    // One clock: check DUT outputs against the model, then drive next inputs.
    task automatic cycle_step();
        bit  exp_arv, exp_ov, exp_done;
        int  lat, due;
        @(negedge clk);
        if (cmd_fire) begin
            accepted = 1;
            cmd_fire = 0;
        end
        if (prev_wait) begin
            chk("ar_hold_valid", 64'(ar_valid), 64'd1);
            chk("ar_hold_addr",  64'(ar_addr),  64'(prev_addr));
        end
        exp_arv  = accepted && (hs < int'(cur.len)) && ((hs - pops) < DEPTH);
        exp_ov   = (delivered - pops) != 0;
        exp_done = accepted && (((cur.len == 0) && (cyc == cmd_cyc + 1)) ||
                   ((cur.len != 0) && (pops == int'(cur.len)) && (cyc == last_pop_cyc + 1)));
        chk("ar_valid",  64'(ar_valid),  64'(exp_arv));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("out_last",  64'(out_last),  64'(exp_ov && (pops == int'(cur.len) - 1)));
        chk("err",       64'(err),       64'(err_exp));
        chk("busy",      64'(busy),      64'(accepted));
        chk("cmd_ready", 64'(cmd_ready), 64'(!accepted));
        chk("done",      64'(done),      64'(exp_done));
        if (done) begin
            dones++;
            accepted = 0;
        end

        r_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r_valid = 1'b1;
            r_data  = pend[0].data;
            void'(pend.pop_front());
            delivered++;
        end

        if (accepted && stall_left > 0) begin
            out_ready = 1'b0;
            if (stall_left == 1 && cur.stall > 0)
                chk("stall_credit_hs", 64'(hs), 64'(cur.exp_stall_hs));
            stall_left--;
        end else begin
            out_ready = ($urandom_range(99) < 32'(cur.out_pct));
        end
        if (out_valid && out_ready) begin
            if (pops < exp_data.size()) begin
                chk("out_data", 64'(out_data), 64'(exp_data[pops]));
            end else begin
                chk("extra_beat", 64'(pops), 64'(exp_data.size()));
            end
            last_pop_cyc = cyc;
            pops++;
        end

        ar_ready  = ($urandom_range(99) < 32'(cur.ar_pct));
        prev_wait = ar_valid && !ar_ready;
        prev_addr = ar_addr;
        if (ar_valid && ar_ready) begin
            if (hs < exp_addr.size()) begin
                chk("ar_addr", 64'(ar_addr), 64'(exp_addr[hs]));
            end else begin
                chk("extra_ar", 64'(hs), 64'(exp_addr.size()));
            end
            lat = cur.fixed_lat ? 2 : int'($urandom_range(1, 3));
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            pend.push_back('{data: line_data(ar_addr), due: due});
            if (hs == 0) first_hs_cyc = cyc;
            last_hs_cyc  = cyc;
            last_ar_addr = ar_addr;
            hs++;
        end

        cmd_valid = 1'b0;
        if (want_cmd && cmd_ready) begin
            cmd_valid  = 1'b1;
            cmd_addr   = cur.addr;
            cmd_stride = cur.stride;
            cmd_len    = cur.len;
            want_cmd   = 0;
            cmd_fire   = 1;
            cmd_cyc    = cyc;
            stall_left = cur.stall;
        end
        cyc++;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int n;
        model_setup(v);
        n = 0;
        while (dones == 0 && n < 500) begin
            cycle_step();
            n++;
        end
        cycle_step();
        chk({tag, "_done_count"}, 64'(dones), 64'd1);
        chk({tag, "_ar_count"},   64'(hs),    64'(v.len));
        chk({tag, "_beat_count"}, 64'(pops),  64'(v.len));
        if (v.len != 0) chk({tag, "_last_addr"}, 64'(last_ar_addr), 64'(v.exp_last_addr));
        if (v.b2b) begin
            chk({tag, "_first_ar_lat"}, 64'(first_hs_cyc), 64'(cmd_cyc + 1));
            chk({tag, "_ar_b2b"}, 64'(last_hs_cyc - first_hs_cyc), 64'(int'(v.len) - 1));
        end
    endtask

    initial begin
        vec_t rv;
        tbl[0] = '{32'h10,        32'h4,  16'd3,  100, 100, 0,  1, 1, 0, 32'h18};
        tbl[1] = '{32'h100,       32'h20, 16'd8,  100, 100, 20, 0, 0, 4, 32'h1E0};
        tbl[2] = '{32'h2000,      32'h40, 16'd6,  50,  100, 0,  0, 0, 0, 32'h2140};
        tbl[3] = '{32'h500,       32'h4,  16'd0,  100, 100, 0,  1, 0, 0, 32'h0};
        tbl[4] = '{32'hFFFF_FFFE, 32'h1,  16'd3,  100, 100, 0,  1, 1, 0, 32'h0};
        tbl[5] = '{32'h0,         32'h1,  16'd12, 100, 100, 0,  1, 1, 0, 32'hB};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_stride = '0; cmd_len = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; out_ready = 1'b0;
        err_exp = 0; cur = tbl[0];
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_cmd(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            rv.addr      = $urandom;
            rv.stride    = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 64));
            rv.len       = 16'($urandom_range(1, 12));
            rv.ar_pct    = int'($urandom_range(20, 100));
            rv.out_pct   = int'($urandom_range(20, 100));
            rv.stall     = 0;
            rv.fixed_lat = 0;
            rv.b2b       = 0;
            rv.exp_stall_hs  = 0;
            rv.exp_last_addr = rv.addr + rv.stride * 32'(rv.len - 16'd1);
            run_cmd(rv, $sformatf("rand%0d", i));
        end

        // Spurious response while idle
        @(negedge clk);
        r_valid = 1'b1; r_data = 32'hDEAD_BEEF;
        @(negedge clk);
        r_valid = 1'b0;
        err_exp = 1;
        chk("spurious_err", 64'(err), 64'd1);
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 5; i++) cycle_step();

        // Reset while draining with two beats buffered
        model_setup('{32'h40, 32'h8, 16'd2, 100, 0, 1000, 1, 0, 0, 32'h48});
        for (int i = 0; i < 10; i++) cycle_step();
        chk("pre_reset_busy", 64'(busy), 64'd1);
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        chk("pre_reset_buffered", 64'(delivered - pops), 64'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        model_clear();
        err_exp = 0;
        cmd_valid = 1'b0; r_valid = 1'b0; ar_ready = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd('{32'h300, 32'h10, 16'd5, 70, 70, 0, 0, 0, 0, 32'h340}, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
